// File: rtl/tag_lookup_ctrl_if.sv
// tag_lookup_ctrl_if
//   Groups the request and response channels of the tag lookup controller.
//   Parameters: AWIDTH (set index width), DWIDTH (tag RAM word width);
//   the tag is DWIDTH-2 bits wide.
//   Request channel : req_valid, req_ready, req_op (0 lookup / 1 update),
//                     req_index, req_tag, req_state (MSI state for updates).
//   Response channel: rsp_valid, rsp_ready, rsp_hit, rsp_state, rsp_tag.
//   Modports: master = requester side, slave = controller side.
interface tag_lookup_ctrl_if #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 11
) ();
    localparam int TWIDTH = DWIDTH - 2;

    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [AWIDTH-1:0] req_index;
    logic [TWIDTH-1:0] req_tag;
    logic [1:0]        req_state;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [1:0]        rsp_state;
    logic [TWIDTH-1:0] rsp_tag;

    modport master (
        output req_valid, req_op, req_index, req_tag, req_state, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_state, rsp_tag
    );

    modport slave (
        input  req_valid, req_op, req_index, req_tag, req_state, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_state, rsp_tag
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl
//   Single-outstanding-request controller for a synchronous-read tag RAM.
//   A lookup reads the set and compares the stored tag/state against the
//   request; an update writes {state, tag} into the set. Entry format is
//   {state[1:0], tag}, states 00=I, 01=S, 10=M, 11=reserved (never hits).
//   Ports:
//     clock, rst_n : clock (posedge) and asynchronous active-low reset
//     bus          : tag_lookup_ctrl_if.slave request/response channels
//     ram_addr     : tag RAM address (always the registered request index)
//     ram_din      : tag RAM write data {req_state, req_tag}
//     ram_we       : tag RAM write enable, high only in the write cycle
//     ram_dout     : tag RAM read data, valid the cycle after the address
//   Optional feature (macro TAG_STATS_EN):
//     stats_clr    : synchronous clear of both counters (has priority)
//     hit_cnt      : saturating count of lookups that hit
//     miss_cnt     : saturating count of lookups that missed
module tag_lookup_ctrl #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 11
) (
    input  logic              clock,
    input  logic              rst_n,
    tag_lookup_ctrl_if.slave  bus,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout
`ifdef TAG_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);
    localparam int TWIDTH = DWIDTH - 2;

    typedef enum logic [2:0] {IDLE, RD, CMP, WR, RSP} state_t;

    state_t state;
    state_t next_state;

    logic              req_op_q;
    logic [AWIDTH-1:0] req_index_q;
    logic [TWIDTH-1:0] req_tag_q;
    logic [1:0]        req_state_q;

    logic              rsp_hit_q;
    logic [1:0]        rsp_state_q;
    logic [TWIDTH-1:0] rsp_tag_q;

    logic              accept;
    logic [1:0]        dout_state;
    logic [TWIDTH-1:0] dout_tag;
    logic              dout_hit;

    assign accept     = bus.req_valid && bus.req_ready;
    assign dout_state = ram_dout[DWIDTH-1 -: 2];
    assign dout_tag   = ram_dout[TWIDTH-1:0];
    // Only S and M are valid states; I and the reserved encoding never hit.
    assign dout_hit   = ((dout_state == 2'b01) || (dout_state == 2'b10)) &&
                        (dout_tag == req_tag_q);

    assign ram_addr      = req_index_q;
    assign ram_din       = {req_state_q, req_tag_q};
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_state = rsp_state_q;
    assign bus.rsp_tag   = rsp_tag_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Lookup: IDLE->RD->CMP->RSP (RAM read latency covered by RD).
    // Update: IDLE->WR->RSP. Strobes are decoded from the state alone so an
    // asynchronous reset drops ram_we and rsp_valid without waiting for a clock.
    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        ram_we        = 1'b0;
        unique case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = bus.req_op ? WR : RD;
                end
            end
            RD:  next_state = CMP;
            CMP: next_state = RSP;
            WR: begin
                ram_we     = req_op_q;
                next_state = RSP;
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured on acceptance and held for the whole
    // transaction; response fields are loaded in CMP or WR and then held
    // stable throughout RSP.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            req_op_q    <= 1'b0;
            req_index_q <= '0;
            req_tag_q   <= '0;
            req_state_q <= 2'b00;
            rsp_hit_q   <= 1'b0;
            rsp_state_q <= 2'b00;
            rsp_tag_q   <= '0;
        end else begin
            if (accept) begin
                req_op_q    <= bus.req_op;
                req_index_q <= bus.req_index;
                req_tag_q   <= bus.req_tag;
                req_state_q <= bus.req_state;
            end
            if (state == CMP) begin
                rsp_hit_q   <= dout_hit;
                rsp_state_q <= dout_state;
                rsp_tag_q   <= dout_tag;
            end else if (state == WR) begin
                rsp_hit_q   <= 1'b0;
                rsp_state_q <= req_state_q;
                rsp_tag_q   <= req_tag_q;
            end
        end
    end

`ifdef TAG_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Every compare cycle counts as exactly one hit or one miss; reserved
    // entries count as misses. Counters stick at all-ones.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else if (stats_clr) begin
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
        end else if (state == CMP) begin
            if (dout_hit) begin
                if (hit_cnt_q != 16'hFFFF) begin
                    hit_cnt_q <= hit_cnt_q + 16'h0001;
                end
            end else begin
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'h0001;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// tb_tag_lookup_ctrl
//   Self-checking bench for tag_lookup_ctrl (AWIDTH=3, DWIDTH=11).
//   Provides a synchronous-read tag RAM, drives directed and random
//   lookup/update transactions, and predicts every response from a
//   per-set table of {state, tag} entries. Stats checks are compiled in
//   when TAG_STATS_EN is defined.
module tb_tag_lookup_ctrl;
    localparam int AWIDTH = 3;
    localparam int DWIDTH = 11;
    localparam int NSETS  = 1 << AWIDTH;

    typedef struct {
        logic [1:0] st;
        logic [8:0] tag;
    } entry_t;

    logic              clock;
    logic              rst_n;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;
    logic [DWIDTH-1:0] ram_mem [NSETS];

    entry_t model [NSETS];

    int assert_count;
    int fail_count;

`ifdef TAG_STATS_EN
    logic        stats_clr;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    tag_lookup_ctrl_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) bus ();

    tag_lookup_ctrl #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
`ifdef TAG_STATS_EN
        ,
        .stats_clr(stats_clr),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM: read data reflects the old contents of the address.
    always @(posedge clock) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // One full transaction: present, wait for acceptance, track the busy
    // cycles, check the response against the table, hold rsp_ready low for
    // hold_cycles, then complete the handshake.
    task automatic applyStimulus(input logic op, input logic [2:0] idx,
                                 input logic [8:0] tag, input logic [1:0] st,
                                 input int hold_cycles);
        logic       exp_hit;
        logic [1:0] exp_state;
        logic [8:0] exp_tag;
        logic       s_hit;
        logic [1:0] s_state;
        logic [8:0] s_tag;
        int         exp_lat;
        int         k;
        int         we_cycles;
        int         wait_cnt;

        if (op) begin
            exp_hit   = 1'b0;
            exp_state = st;
            exp_tag   = tag;
            exp_lat   = 2;
        end else begin
            exp_state = model[idx].st;
            exp_tag   = model[idx].tag;
            exp_hit   = ((exp_state == 2'b01) || (exp_state == 2'b10)) &&
                        (exp_tag == tag);
            exp_lat   = 3;
        end

        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_index = idx;
        bus.req_tag   = tag;
        bus.req_state = st;
        wait_cnt = 0;
        while (!bus.req_ready && wait_cnt < 16) begin
            @(negedge clock);
            wait_cnt++;
        end
        checkOutput("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;

        k = 1;
        we_cycles = 0;
        while (!bus.rsp_valid && k < 10) begin
            checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
            checkOutput("ram_addr_busy", 32'(ram_addr), 32'(idx));
            if (ram_we) begin
                we_cycles++;
                checkOutput("write_cycle", k, 32'd1);
                checkOutput("ram_din_on_write", 32'(ram_din), 32'({st, tag}));
            end
            @(negedge clock);
            k++;
        end
        checkOutput("rsp_latency", k, exp_lat);
        checkOutput("ram_we_cycles", we_cycles, op ? 32'd1 : 32'd0);
        checkOutput("rsp_hit", 32'(bus.rsp_hit), 32'(exp_hit));
        checkOutput("rsp_state", 32'(bus.rsp_state), 32'(exp_state));
        checkOutput("rsp_tag", 32'(bus.rsp_tag), 32'(exp_tag));

        if (op) begin
            model[idx] = '{st, tag};
        end

        s_hit   = bus.rsp_hit;
        s_state = bus.rsp_state;
        s_tag   = bus.rsp_tag;
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clock);
            checkOutput("rsp_valid_hold", 32'(bus.rsp_valid), 32'd1);
            checkOutput("req_ready_hold", 32'(bus.req_ready), 32'd0);
            checkOutput("ram_we_hold", 32'(ram_we), 32'd0);
            checkOutput("rsp_stable", 32'({bus.rsp_hit, bus.rsp_state, bus.rsp_tag}),
                        32'({s_hit, s_state, s_tag}));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_hs", 32'(bus.rsp_valid), 32'd0);
        checkOutput("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rnd;
        logic        r_op;
        logic [2:0]  r_idx;
        logic [8:0]  r_tag;
        logic [1:0]  r_st;

        assert_count  = 0;
        fail_count    = 0;
        clock         = 1'b0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_index = '0;
        bus.req_tag   = '0;
        bus.req_state = 2'b00;
        bus.rsp_ready = 1'b0;
`ifdef TAG_STATS_EN
        stats_clr     = 1'b0;
`endif

        #3;
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_rsp_hit", 32'(bus.rsp_hit), 32'd0);
        checkOutput("reset_rsp_state", 32'(bus.rsp_state), 32'd0);
        checkOutput("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset_ram_din", 32'(ram_din), 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        #1;
        checkOutput("req_ready_after_por", 32'(bus.req_ready), 32'd1);

        // Give every set a defined entry before any lookup.
        for (int i = 0; i < NSETS; i++) begin
            rnd = $urandom;
            applyStimulus(1'b1, 3'(i), rnd[8:0], rnd[10:9], 0);
        end

        // Directed scenarios around set 5.
        applyStimulus(1'b1, 3'd5, 9'h1A3, 2'b10, 0);
        applyStimulus(1'b0, 3'd5, 9'h1A3, 2'b00, 0);
        applyStimulus(1'b0, 3'd5, 9'h0A3, 2'b00, 0);
        applyStimulus(1'b1, 3'd5, 9'h1A3, 2'b00, 0);
        applyStimulus(1'b0, 3'd5, 9'h1A3, 2'b00, 0);
        applyStimulus(1'b1, 3'd2, 9'h0F0, 2'b01, 4);
        applyStimulus(1'b0, 3'd2, 9'h0F0, 2'b00, 4);

        // Reset while the write strobe is active: no write, no response.
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b1;
        bus.req_index = 3'd3;
        bus.req_tag   = 9'h055;
        bus.req_state = 2'b10;
        @(posedge clock);
        @(negedge clock);
        bus.req_valid = 1'b0;
        checkOutput("ram_we_in_wr", 32'(ram_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ram_we_async_reset", 32'(ram_we), 32'd0);
        checkOutput("rsp_valid_async_reset", 32'(bus.rsp_valid), 32'd0);
        checkOutput("ram_din_async_reset", 32'(ram_din), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        checkOutput("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("no_rsp_after_reset", 32'(bus.rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 3'd3, model[3].tag, 2'b00, 0);

`ifdef TAG_STATS_EN
        @(negedge clock);
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        applyStimulus(1'b1, 3'd0, 9'h001, 2'b10, 0);
        applyStimulus(1'b1, 3'd1, 9'h002, 2'b01, 0);
        applyStimulus(1'b1, 3'd2, 9'h003, 2'b11, 0);
        applyStimulus(1'b0, 3'd0, 9'h001, 2'b00, 0);
        applyStimulus(1'b0, 3'd1, 9'h002, 2'b00, 0);
        applyStimulus(1'b0, 3'd0, 9'h001, 2'b00, 0);
        applyStimulus(1'b0, 3'd0, 9'h005, 2'b00, 0);
        applyStimulus(1'b0, 3'd1, 9'h007, 2'b00, 0);
        applyStimulus(1'b0, 3'd2, 9'h003, 2'b00, 0);
        checkOutput("hit_cnt", 32'(hit_cnt), 32'd3);
        checkOutput("miss_cnt", 32'(miss_cnt), 32'd3);
        @(negedge clock);
        stats_clr = 1'b1;
        @(negedge clock);
        stats_clr = 1'b0;
        checkOutput("hit_cnt_clr", 32'(hit_cnt), 32'd0);
        checkOutput("miss_cnt_clr", 32'(miss_cnt), 32'd0);
        force dut.miss_cnt_q = 16'hFFFF;
        @(negedge clock);
        release dut.miss_cnt_q;
        applyStimulus(1'b0, 3'd0, 9'h0AA, 2'b00, 0);
        checkOutput("miss_cnt_saturate", 32'(miss_cnt), 32'h0000FFFF);
`endif

        // Random traffic; half of the lookups reuse the stored tag to hit.
        for (int n = 0; n < 40; n++) begin
            rnd   = $urandom;
            r_op  = rnd[0];
            r_idx = rnd[3:1];
            r_st  = rnd[5:4];
            r_tag = rnd[14:6];
            if (!r_op && rnd[15]) begin
                r_tag = model[r_idx].tag;
            end
            applyStimulus(r_op, r_idx, r_tag, r_st, 32'(rnd[17:16]) % 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/tag_lookup_ctrl.md
TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

Interface
REQ-001 Parameter AWIDTH, default 3, tag RAM index width (2^AWIDTH sets).
REQ-002 Parameter DWIDTH, default 11, tag RAM word width; localparam TWIDTH = DWIDTH-2 is the tag width.
REQ-003 clock  input  1  single clock, all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid, req_ready  input/output  1 each  request handshake.
REQ-006 req_op  input  1  0 = lookup, 1 = update.
REQ-007 req_index  input  AWIDTH  set index; req_tag  input  TWIDTH  tag; req_state  input  2  MSI state written on update.
REQ-008 ram_addr  output  AWIDTH; ram_din  output  DWIDTH; ram_we  output  1; ram_dout  input  DWIDTH. These drive a synchronous-read tag RAM: address sampled on the edge, data valid the following cycle.
REQ-009 rsp_valid, rsp_ready  output/input  1 each  response handshake.
REQ-010 rsp_hit  output  1; rsp_state  output  2; rsp_tag  output  TWIDTH (stored tag, for victim writeback).

Function
REQ-011 Entry format SHALL be {state[1:0], tag[TWIDTH-1:0]}; states 00=I, 01=S, 10=M, 11=reserved.
REQ-012 FSM states SHALL be IDLE, RD, CMP, WR, RSP; req_ready=1 only in IDLE.
REQ-013 IDLE: on req_valid&&req_ready, op/index/tag/state SHALL be registered; next state RD if lookup, WR if update.
REQ-014 ram_addr SHALL equal the registered index in every state; ram_din = {req_state_q, req_tag_q}.
REQ-015 RD: ram_we=0, one cycle, then CMP.
REQ-016 CMP: rsp_hit = (ram_dout state is 01 or 10) && (ram_dout tag == req_tag_q); rsp_state/rsp_tag = ram_dout fields; registered, then RSP.
REQ-017 Reserved state 11 SHALL report rsp_hit=0, rsp_state=11.
REQ-018 WR: ram_we=1 for exactly one cycle, then RSP with rsp_hit=0, rsp_state=req_state_q, rsp_tag=req_tag_q; update with state I invalidates the set.
REQ-019 ram_we SHALL be 0 in every state other than WR.
REQ-020 RSP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready, then IDLE; next request accepted no earlier than the following cycle.
REQ-021 Latency: accept edge T0; lookup rsp_valid first high at T3; update rsp_valid first high at T2.
REQ-022 No request is dropped or reordered; at most one request is outstanding.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, ram_we=0, rsp_valid=0, rsp_hit=0, rsp_state=00, rsp_tag=0, all registered request fields 0.
REQ-024 Reset during WR SHALL deassert ram_we before the next edge; the in-flight request is discarded and no response is given.
REQ-025 After rst_n rises, req_ready SHALL be 1 on the first cycle.

Configuration
REQ-026 Macro TAG_STATS_EN: when defined, add input stats_clr (1) and outputs hit_cnt, miss_cnt (16 each).
REQ-027 With TAG_STATS_EN, each CMP cycle increments hit_cnt or miss_cnt, saturating at 0xFFFF; stats_clr clears both synchronously and takes priority; reset clears both to 0.
REQ-028 Without TAG_STATS_EN, these ports and counters SHALL be absent; behaviour is otherwise identical.

Verification
REQ-029 Assert rst_n low in WR cycle -> ram_we 0 with no clock edge, rsp_valid 0; release -> req_ready 1 on the next cycle.
REQ-030 Update index 5, tag 0x1A3, state M -> ram_we high exactly one cycle at T1, ram_addr 5, ram_din 0x5A3; rsp_valid at T2, rsp_state 10.
REQ-031 Lookup index 5, tag 0x1A3 -> rsp_valid at T3, rsp_hit 1, rsp_state 10, rsp_tag 0x1A3; ram_we stays 0.
REQ-032 Lookup index 5, tag 0x0A3 -> rsp_hit 0, rsp_tag 0x1A3, rsp_state 10; then update index 5 with state I, and a re-lookup with tag 0x1A3 -> rsp_hit 0.
REQ-033 Hold rsp_ready low for 4 cycles in RSP -> outputs stable and req_ready 0 throughout; handshake -> IDLE, next request accepted the cycle after.
REQ-034 TAG_STATS_EN: 3 hits, 2 misses and 1 reserved-state lookup -> hit_cnt 3, miss_cnt 3; pulse stats_clr -> both 0; preload miss_cnt 0xFFFF, then one miss -> remains 0xFFFF.
